// File: rtl/adder_module.sv
// Multi-cycle 15-bit adder: three 5-bit slices over S0..S2, one operation per 4 cycles.
// Optional macro ADDER_SAT_EN clamps SUM to 0x7FFF whenever the final carry is set.
module adder_module (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DE,
    input  logic [14:0] X,
    input  logic [14:0] Y,
    input  logic        Cin,
    output logic        OE,
    output logic [14:0] SUM,
    output logic        Cout,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S0   = 2'd1,
        S1   = 2'd2,
        S2   = 2'd3
    } state_t;

    state_t      state_r, state_next_s;
    logic [14:0] x_r, x_next_s;
    logic [14:0] y_r, y_next_s;
    logic        cin_r, cin_next_s;
    logic        carry_r, carry_next_s;
    logic [9:0]  psum_r, psum_next_s;
    logic [14:0] sum_next_s;
    logic        cout_next_s;
    logic        oe_next_s;
    logic        busy_next_s;
    logic [5:0]  slice_s;
    logic [14:0] full_s;

    // 5-bit slice add; bit 5 of the result is the slice carry-out
    function automatic logic [5:0] slice_add(input logic [4:0] a,
                                             input logic [4:0] b,
                                             input logic       c);
        return {1'b0, a} + {1'b0, b} + {5'd0, c};
    endfunction

    // Next-state and next-register values; every register holds unless its state updates it
    always_comb begin
        state_next_s = state_r;
        x_next_s     = x_r;
        y_next_s     = y_r;
        cin_next_s   = cin_r;
        carry_next_s = carry_r;
        psum_next_s  = psum_r;
        sum_next_s   = SUM;
        cout_next_s  = Cout;
        oe_next_s    = 1'b0;
        busy_next_s  = BUSY;
        slice_s      = 6'd0;
        full_s       = 15'd0;
        case (state_r)
            IDLE: begin
                if (DE) begin
                    x_next_s     = X;
                    y_next_s     = Y;
                    cin_next_s   = Cin;
                    busy_next_s  = 1'b1;
                    state_next_s = S0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            S0: begin
                slice_s           = slice_add(x_r[4:0], y_r[4:0], cin_r);
                psum_next_s[4:0]  = slice_s[4:0];
                carry_next_s      = slice_s[5];
                state_next_s      = S1;
            end
            S1: begin
                slice_s           = slice_add(x_r[9:5], y_r[9:5], carry_r);
                psum_next_s[9:5]  = slice_s[4:0];
                carry_next_s      = slice_s[5];
                state_next_s      = S2;
            end
            S2: begin
                slice_s      = slice_add(x_r[14:10], y_r[14:10], carry_r);
                full_s       = {slice_s[4:0], psum_r};
                carry_next_s = slice_s[5];
                cout_next_s  = slice_s[5];
`ifdef ADDER_SAT_EN
                sum_next_s   = slice_s[5] ? 15'h7FFF : full_s;
`else
                sum_next_s   = full_s;
`endif
                oe_next_s    = 1'b1;
                busy_next_s  = 1'b0;
                state_next_s = IDLE;
            end
            default: begin
                busy_next_s  = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // State, operand, slice and output registers; RST overrides any operation in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            x_r     <= 15'd0;
            y_r     <= 15'd0;
            cin_r   <= 1'b0;
            carry_r <= 1'b0;
            psum_r  <= 10'd0;
            SUM     <= 15'd0;
            Cout    <= 1'b0;
            OE      <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            x_r     <= x_next_s;
            y_r     <= y_next_s;
            cin_r   <= cin_next_s;
            carry_r <= carry_next_s;
            psum_r  <= psum_next_s;
            SUM     <= sum_next_s;
            Cout    <= cout_next_s;
            OE      <= oe_next_s;
            BUSY    <= busy_next_s;
        end
    end

endmodule
